vga_fb_write_ctrl: RTL and testbench

//  Arbitrates the single frame-buffer write port (addr_x/addr_y/color/we) of vga_mem_wrapper.

---
 rtl/vga_fb_write_ctrl_pkg.sv | 20 ++
 rtl/vga_fb_write_ctrl_if.sv | 35 +++
 rtl/vga_rr_arb2.sv | 41 ++++
 rtl/vga_fb_write_ctrl.sv | 115 +++++++++++
 tb/tb_vga_fb_write_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_fb_write_ctrl_pkg.sv
// Shared definitions for the frame-buffer write controller: default geometry,
// controller state encoding and a pixel-write record.
package vga_fb_write_ctrl_pkg;

    localparam int HD_DEF      = 1280;
    localparam int VD_DEF      = 1024;
    localparam int COORD_W_DEF = 11;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_e;

    typedef struct packed {
        logic [COORD_W_DEF-1:0] x;
        logic [COORD_W_DEF-1:0] y;
        logic                   color;
    } pixel_wr_t;

endpackage

// File: rtl/vga_fb_write_ctrl_if.sv
// Bus bundle between the pixel requesters / clear trigger and the frame-buffer
// write controller, plus the registered frame-buffer write port.
interface vga_fb_write_ctrl_if #(
    parameter int COORD_W = 11
);
    import vga_fb_write_ctrl_pkg::*;

    logic                   clear_start_i;
    logic                   clear_color_i;
    logic                   clear_busy_o;
    // Requester i transfers in a cycle where req_valid_i[i] & req_ready_o[i];
    // a requester keeps valid and its payload stable until that cycle.
    logic [1:0]             req_valid_i;
    logic [2*COORD_W-1:0]   req_x_i;
    logic [2*COORD_W-1:0]   req_y_i;
    logic [1:0]             req_color_i;
    logic [1:0]             req_ready_o;
    logic                   oob_o;
    logic [COORD_W-1:0]     addr_x_o;
    logic [COORD_W-1:0]     addr_y_o;
    logic                   color_o;
    logic                   we_o;
    fb_state_e              state_o;

    modport slave (
        input  clear_start_i, clear_color_i, req_valid_i, req_x_i, req_y_i, req_color_i,
        output clear_busy_o, req_ready_o, oob_o, addr_x_o, addr_y_o, color_o, we_o, state_o
    );

    modport master (
        output clear_start_i, clear_color_i, req_valid_i, req_x_i, req_y_i, req_color_i,
        input  clear_busy_o, req_ready_o, oob_o, addr_x_o, addr_y_o, color_o, we_o, state_o
    );

endinterface

// File: rtl/vga_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer advances
// past whichever requester was granted.
module vga_rr_arb2 (
    input  logic       clk_i,
    input  logic       arstn_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    // ptr_q names the requester that wins the next tie.
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
        ptr_d = ptr_q;
        if (gnt_o[0]) begin
            ptr_d = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vga_fb_write_ctrl.sv
// Owns the single frame-buffer write port: arbitrates two pixel requesters and
// a full-frame clear sweep, range-checks requests and registers the write.
module vga_fb_write_ctrl
    import vga_fb_write_ctrl_pkg::*;
#(
    parameter int HD      = HD_DEF,
    parameter int VD      = VD_DEF,
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    vga_fb_write_ctrl_if.slave bus
);

    // One extra bit so the limit compare works even when HD or VD equals 2**COORD_W.
    localparam logic [COORD_W:0]   HD_LIM = (COORD_W+1)'(HD);
    localparam logic [COORD_W:0]   VD_LIM = (COORD_W+1)'(VD);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(HD - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(VD - 1);

    fb_state_e          state_q;
    logic [COORD_W-1:0] cx_q, cy_q, cx_d, cy_d;
    logic [COORD_W-1:0] ax_q, ay_q;
    logic               clr_col_q, busy_q, we_q, oob_q, col_q;

    logic [1:0]         gnt;
    logic               arb_en, sel, sel_c, in_rng, sweep_last;
    logic [COORD_W-1:0] sel_x, sel_y;

    // The clear trigger outranks requesters in the cycle it arrives.
    assign arb_en = arstn_i && (state_q == IDLE) && !bus.clear_start_i;

    vga_rr_arb2 u_arb (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .req_i   (bus.req_valid_i),
        .en_i    (arb_en),
        .gnt_o   (gnt)
    );

    always_comb begin
        sel        = gnt[1];
        sel_x      = sel ? bus.req_x_i[COORD_W +: COORD_W] : bus.req_x_i[0 +: COORD_W];
        sel_y      = sel ? bus.req_y_i[COORD_W +: COORD_W] : bus.req_y_i[0 +: COORD_W];
        sel_c      = bus.req_color_i[sel];
        in_rng     = ({1'b0, sel_x} < HD_LIM) && ({1'b0, sel_y} < VD_LIM);
        sweep_last = (cx_q == X_LAST) && (cy_q == Y_LAST);
        cx_d       = cx_q + COORD_W'(1);
        cy_d       = cy_q;
        if (cx_q == X_LAST) begin
            cx_d = '0;
            cy_d = cy_q + COORD_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q   <= IDLE;
            cx_q      <= '0;
            cy_q      <= '0;
            clr_col_q <= 1'b0;
            busy_q    <= 1'b0;
            we_q      <= 1'b0;
            oob_q     <= 1'b0;
            ax_q      <= '0;
            ay_q      <= '0;
            col_q     <= 1'b0;
        end else begin
            we_q  <= 1'b0;
            oob_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.clear_start_i) begin
                        state_q   <= CLEAR;
                        busy_q    <= 1'b1;
                        clr_col_q <= bus.clear_color_i;
                        cx_q      <= '0;
                        cy_q      <= '0;
                    end else if (|gnt) begin
                        if (in_rng) begin
                            we_q  <= 1'b1;
                            ax_q  <= sel_x;
                            ay_q  <= sel_y;
                            col_q <= sel_c;
                        end else begin
                            oob_q <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    we_q  <= 1'b1;
                    ax_q  <= cx_q;
                    ay_q  <= cy_q;
                    col_q <= clr_col_q;
                    cx_q  <= cx_d;
                    cy_q  <= cy_d;
                    if (sweep_last) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.req_ready_o  = gnt;
    assign bus.clear_busy_o = busy_q;
    assign bus.oob_o        = oob_q;
    assign bus.we_o         = we_q;
    assign bus.addr_x_o     = ax_q;
    assign bus.addr_y_o     = ay_q;
    assign bus.color_o      = col_q;
    assign bus.state_o      = state_q;

endmodule

// File: tb/tb_vga_fb_write_ctrl.sv
// Bench for vga_fb_write_ctrl on a small 4x3 frame: grant vectors from a table,
// writes/oob pulses checked against a cycle-stamped expected queue.
module tb_vga_fb_write_ctrl;
  import vga_fb_write_ctrl_pkg::*;

  localparam int HD = 4;
  localparam int VD = 3;
  localparam int CW = 11;
  localparam int EW = 2 + 2*CW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arstn = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_fb_write_ctrl_if #(.COORD_W(CW)) bus ();

  vga_fb_write_ctrl #(.HD(HD), .VD(VD), .COORD_W(CW)) dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .bus     (bus)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            errors = 0;
  int            checks = 0;

  typedef struct {
    logic [1:0] v;
    int         x0, y0;
    logic       c0;
    int         x1, y1;
    logic       c1;
    logic [1:0] rdy;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [EW-1:0] wr_ent(input int x, input int y, input logic c);
    return {1'b0, 1'b1, CW'(x), CW'(y), c};
  endfunction

  function automatic logic [EW-1:0] oob_ent();
    return {1'b1, {(EW-1){1'b0}}};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [EW-1:0] e, input int at_cyc);
    exp_q.push_back(e);
    exp_cyc_q.push_back(at_cyc);
  endtask

  task automatic sb_check();
    logic [EW-1:0] act;
    logic [EW-1:0] e;
    if (!arstn) return;
    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL sb_missing: got nothing expected %0h at cycle %0d", exp_q[0], exp_cyc_q[0]);
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
    act = {bus.oob_o, bus.we_o,
           bus.we_o ? {bus.addr_x_o, bus.addr_y_o, bus.color_o} : {(2*CW+1){1'b0}}};
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
      checks++;
      e = exp_q.pop_front();
      void'(exp_cyc_q.pop_front());
      if (act !== e) begin
        errors++;
        $display("FAIL sb_write: got %0h expected %0h (cycle %0d)", act, e, cyc);
      end
    end else if (bus.we_o !== 1'b0 || bus.oob_o !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: got we=%0b oob=%0b expected none (cycle %0d)",
               bus.we_o, bus.oob_o, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(negedge clk);
    sb_check();
  endtask

  task automatic set_req(input logic [1:0] v, input int x0, input int y0, input logic c0,
                         input int x1, input int y1, input logic c1);
    bus.req_valid_i = v;
    bus.req_x_i     = {CW'(x1), CW'(x0)};
    bus.req_y_i     = {CW'(y1), CW'(y0)};
    bus.req_color_i = {c1, c0};
  endtask

  // Expected outcome of a grant: a write next cycle when in range, else an oob pulse.
  task automatic push_grant(input logic [1:0] rdy, input int x0, input int y0, input logic c0,
                            input int x1, input int y1, input logic c1);
    int x, y;
    logic c;
    if (rdy == 2'b00) return;
    x = rdy[1] ? x1 : x0;
    y = rdy[1] ? y1 : y0;
    c = rdy[1] ? c1 : c0;
    if (x < HD && y < VD) push_exp(wr_ent(x, y, c), cyc + 1);
    else                  push_exp(oob_ent(), cyc + 1);
  endtask

  task automatic push_sweep(input logic c, input int n_wr, input int start_cyc);
    for (int k = 0; k < n_wr; k++) push_exp(wr_ent(k % HD, k / HD, c), start_cyc + 2 + k);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_we"},    32'(bus.we_o), 0);
    chk({nm, "_ax"},    32'(bus.addr_x_o), 0);
    chk({nm, "_ay"},    32'(bus.addr_y_o), 0);
    chk({nm, "_color"}, 32'(bus.color_o), 0);
    chk({nm, "_busy"},  32'(bus.clear_busy_o), 0);
    chk({nm, "_oob"},   32'(bus.oob_o), 0);
    chk({nm, "_ready"}, 32'(bus.req_ready_o), 0);
    chk({nm, "_state"}, 32'(bus.state_o), 32'(IDLE));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- main test ----------------
  initial begin
    int n;
    bus.clear_start_i = 1'b0;
    bus.clear_color_i = 1'b0;
    set_req(2'b00, 0, 0, 0, 0, 0, 0);

    tbl[0]  = '{2'b10, 0, 0, 1'b0, 0, 0, 1'b1, 2'b10};
    tbl[1]  = '{2'b11, 1, 1, 1'b0, 2, 2, 1'b1, 2'b01};
    tbl[2]  = '{2'b11, 1, 1, 1'b0, 2, 2, 1'b1, 2'b10};
    tbl[3]  = '{2'b11, 1, 1, 1'b0, 2, 2, 1'b1, 2'b01};
    tbl[4]  = '{2'b11, 1, 1, 1'b0, 2, 2, 1'b1, 2'b10};
    tbl[5]  = '{2'b00, 0, 0, 1'b0, 0, 0, 1'b0, 2'b00};
    tbl[6]  = '{2'b10, 0, 0, 1'b0, 1280, 0, 1'b1, 2'b10};
    tbl[7]  = '{2'b01, 4, 0, 1'b1, 0, 0, 1'b0, 2'b01};
    tbl[8]  = '{2'b01, 3, 3, 1'b0, 0, 0, 1'b0, 2'b01};
    tbl[9]  = '{2'b01, 3, 2, 1'b0, 0, 0, 1'b0, 2'b01};
    tbl[10] = '{2'b11, 0, 2, 1'b1, 3, 0, 1'b0, 2'b10};
    tbl[11] = '{2'b00, 0, 0, 1'b0, 0, 0, 1'b0, 2'b00};
    tbl[12] = '{2'b11, 2, 0, 1'b1, 1, 2, 1'b1, 2'b01};
    tbl[13] = '{2'b00, 0, 0, 1'b0, 0, 0, 1'b0, 2'b00};

    // Reset values, then a reset landing while a write is on the port.
    repeat (3) @(negedge clk);
    #1 chk_all_zero("rst");
    @(negedge clk);
    arstn = 1'b1;
    next_cycle();
    set_req(2'b01, 1, 1, 1'b1, 0, 0, 1'b0);
    #1 chk("mid_rdy", 32'(bus.req_ready_o), 32'h1);
    push_grant(2'b01, 1, 1, 1'b1, 0, 0, 1'b0);
    next_cycle();
    #2 arstn = 1'b0;
    #1 chk_all_zero("async_rst");
    set_req(2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    arstn = 1'b1;
    // Both valid right after reset: pointer must favour requester 0.
    set_req(2'b11, 3, 2, 1'b1, 0, 1, 1'b0);
    #1 chk("post_rst_rdy", 32'(bus.req_ready_o), 32'h1);
    push_grant(2'b01, 3, 2, 1'b1, 0, 1, 1'b0);

    // Table-driven grant / range vectors.
    for (int i = 0; i < 14; i++) begin
      next_cycle();
      set_req(tbl[i].v, tbl[i].x0, tbl[i].y0, tbl[i].c0, tbl[i].x1, tbl[i].y1, tbl[i].c1);
      #1 chk($sformatf("tbl%0d_rdy", i), 32'(bus.req_ready_o), 32'(tbl[i].rdy));
      push_grant(tbl[i].rdy, tbl[i].x0, tbl[i].y0, tbl[i].c0, tbl[i].x1, tbl[i].y1, tbl[i].c1);
    end

    // Full clear, colour 1, both requesters stalled throughout.
    next_cycle();
    set_req(2'b00, 0, 0, 0, 0, 0, 0);
    bus.clear_start_i = 1'b1;
    bus.clear_color_i = 1'b1;
    n = cyc;
    #1 chk("clr_busy_pre", 32'(bus.clear_busy_o), 0);
    push_sweep(1'b1, HD*VD, n);
    for (int k = 1; k <= HD*VD; k++) begin
      next_cycle();
      bus.clear_start_i = 1'b0;
      bus.clear_color_i = 1'b0;
      set_req(2'b11, 1, 0, 1'b0, 2, 1, 1'b1);
      #1 chk($sformatf("clr_busy%0d", k), 32'(bus.clear_busy_o), 1);
      chk($sformatf("clr_rdy%0d", k), 32'(bus.req_ready_o), 0);
    end
    next_cycle();
    #1 chk("clr_busy_end", 32'(bus.clear_busy_o), 0);
    chk("clr_rdy_end", 32'(bus.req_ready_o), 32'h2);
    push_grant(2'b10, 1, 0, 1'b0, 2, 1, 1'b1);
    next_cycle();
    set_req(2'b00, 0, 0, 0, 0, 0, 0);

    // Clear start colliding with a request; a mid-sweep restart attempt is ignored.
    next_cycle();
    bus.clear_start_i = 1'b1;
    bus.clear_color_i = 1'b0;
    set_req(2'b01, 2, 2, 1'b1, 0, 0, 1'b0);
    n = cyc;
    #1 chk("col_rdy0", 32'(bus.req_ready_o), 0);
    push_sweep(1'b0, HD*VD, n);
    for (int k = 1; k <= HD*VD; k++) begin
      next_cycle();
      bus.clear_start_i = (k == 3);
      bus.clear_color_i = (k == 3);
      #1 chk($sformatf("col_rdy%0d", k), 32'(bus.req_ready_o), 0);
    end
    next_cycle();
    bus.clear_start_i = 1'b0;
    bus.clear_color_i = 1'b0;
    #1 chk("col_rdy_end", 32'(bus.req_ready_o), 32'h1);
    push_grant(2'b01, 2, 2, 1'b1, 0, 0, 1'b0);
    next_cycle();
    set_req(2'b00, 0, 0, 0, 0, 0, 0);

    // Reset after 5 sweep writes, then a fresh clear starts from (0,0).
    next_cycle();
    bus.clear_start_i = 1'b1;
    bus.clear_color_i = 1'b1;
    set_req(2'b01, 0, 0, 1'b1, 0, 0, 1'b0);
    n = cyc;
    push_sweep(1'b1, 5, n);
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      bus.clear_start_i = 1'b0;
      bus.clear_color_i = 1'b0;
    end
    #2 arstn = 1'b0;
    #1 chk_all_zero("rst_clr");
    set_req(2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    arstn = 1'b1;
    bus.clear_start_i = 1'b1;
    n = cyc;
    push_sweep(1'b0, HD*VD, n);
    for (int k = 1; k <= HD*VD; k++) begin
      next_cycle();
      bus.clear_start_i = 1'b0;
    end
    next_cycle();
    #1 chk("restart_busy_end", 32'(bus.clear_busy_o), 0);
    chk("restart_state_end", 32'(bus.state_o), 32'(IDLE));

    repeat (3) next_cycle();
    chk("sb_drain", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
